// File: rtl/pipeline_pkg.sv
// Shared encodings for the MEM stage: access sizes, writeback select, FSM states, timeout default.
package pipeline_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 64;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) || ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/pipeline_mem_if.sv
// Data-memory bus between the MEM stage (master) and the memory (slave).
interface pipeline_mem_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/Mem_align.sv
// Combinational load extraction (shift + sign/zero extend) and store lane replication/strobes.
module Mem_align
  import pipeline_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic        is_store,
  input  logic [31:0] rdata,
  input  logic [31:0] sdata,
  output logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
  assign half_v = rdata[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    load_data = rdata;
    wdata     = sdata;
    wstrb     = 4'b1111;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
        wdata     = {4{sdata[7:0]}};
        wstrb     = 4'b0001 << addr_lo;
      end
      SIZE_HALF: begin
        load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
        wdata     = {2{sdata[15:0]}};
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
      end
      default: ;
    endcase
    if (!is_store) wstrb = '0;
  end

endmodule

// File: rtl/pipeline_mem.sv
// MEM stage: data-memory handshake FSM with timeout, and the MEM/WB pipeline register.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module pipeline_mem
  import pipeline_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] ALU_res_in,
  input  logic [31:0] rs2_data,
  input  logic [31:0] PC_in,
  input  logic [1:0]  MemtoReg_in,
  input  logic        RegWrite_in,
  input  logic [4:0]  rd_in,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        flush,
  output logic        stall,
  pipeline_mem_if.master dmem,
  output logic        wb_valid,
  output logic [31:0] ALU_res,
  output logic [31:0] Mem_res,
  output logic [31:0] PC,
  output logic [1:0]  MemtoReg,
  output logic        RegWrite,
  output logic [4:0]  rd,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic        bus_err
);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        in_wait, memop, trap, issue, req, timeout_hit, done, kill;
  logic        alu_ld, trap_ld;
  logic [31:0] load_data;

  logic        wb_valid_q, wb_valid_d, regwrite_q, regwrite_d, bus_err_q, bus_err_d;
  logic [31:0] alu_q, alu_d, mem_q, mem_d, pc_q, pc_d;
  logic [1:0]  mtr_q, mtr_d;
  logic [4:0]  rd_q, rd_d;
`ifdef MISALIGN_TRAP_EN
  logic        mis_q, mis_d;
`endif

  assign in_wait = (state_q == ST_WAIT);
  assign memop   = in_valid & (MemRead | MemWrite);
`ifdef MISALIGN_TRAP_EN
  assign trap    = memop & is_misaligned(mem_size, ALU_res_in[1:0]);
`else
  assign trap    = 1'b0;
`endif
  assign issue       = ~in_wait & memop & ~flush & ~trap;
  assign req         = ~rst & (issue | in_wait);
  assign timeout_hit = in_wait & (cnt_q == 8'(TIMEOUT - 1));
  assign stall       = req & ~dmem.dmem_ack & ~timeout_hit;
  assign done        = req & (dmem.dmem_ack | timeout_hit);
  // A flush arriving while the bus is busy only marks the result dead; the access still completes.
  assign kill        = kill_q | (in_wait & flush);
  assign alu_ld      = ~in_wait & in_valid & ~memop & ~flush;
  assign trap_ld     = ~in_wait & trap & ~flush;

  assign dmem.dmem_req  = req;
  assign dmem.dmem_we   = MemWrite;
  assign dmem.dmem_addr = {ALU_res_in[31:2], 2'b00};

  Mem_align u_align (
    .addr_lo     (ALU_res_in[1:0]),
    .size        (mem_size),
    .is_unsigned (mem_unsigned),
    .is_store    (MemWrite),
    .rdata       (dmem.dmem_rdata),
    .sdata       (rs2_data),
    .load_data   (load_data),
    .wdata       (dmem.dmem_wdata),
    .wstrb       (dmem.dmem_wstrb)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    if (!in_wait) begin
      if (req && !dmem.dmem_ack) begin
        state_d = ST_WAIT;
        cnt_d   = '0;
        kill_d  = 1'b0;
      end
    end else if (dmem.dmem_ack || timeout_hit) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      kill_d  = 1'b0;
    end else begin
      cnt_d  = cnt_q + 8'd1;
      kill_d = kill;
    end
  end

  always_comb begin
    wb_valid_d = 1'b0;
    regwrite_d = 1'b0;
    bus_err_d  = bus_err_q;
    alu_d      = alu_q;
    mem_d      = mem_q;
    pc_d       = pc_q;
    mtr_d      = mtr_q;
    rd_d       = rd_q;
`ifdef MISALIGN_TRAP_EN
    mis_d      = mis_q;
`endif
    if (done || alu_ld || trap_ld) begin
      alu_d     = ALU_res_in;
      pc_d      = PC_in;
      mtr_d     = MemtoReg_in;
      rd_d      = rd_in;
      mem_d     = '0;
      bus_err_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
      mis_d     = trap_ld;
`endif
      if (done) begin
        wb_valid_d = ~kill;
        // An ack in the timeout cycle still delivers real data.
        if (dmem.dmem_ack) begin
          regwrite_d = RegWrite_in & ~kill;
          mem_d      = MemRead ? load_data : '0;
        end else begin
          bus_err_d  = 1'b1;
        end
      end else begin
        wb_valid_d = 1'b1;
        regwrite_d = alu_ld & RegWrite_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      kill_q     <= 1'b0;
      wb_valid_q <= 1'b0;
      regwrite_q <= 1'b0;
      bus_err_q  <= 1'b0;
      alu_q      <= '0;
      mem_q      <= '0;
      pc_q       <= '0;
      mtr_q      <= '0;
      rd_q       <= '0;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kill_q     <= kill_d;
      wb_valid_q <= wb_valid_d;
      regwrite_q <= regwrite_d;
      bus_err_q  <= bus_err_d;
      alu_q      <= alu_d;
      mem_q      <= mem_d;
      pc_q       <= pc_d;
      mtr_q      <= mtr_d;
      rd_q       <= rd_d;
`ifdef MISALIGN_TRAP_EN
      mis_q      <= mis_d;
`endif
    end
  end

  assign wb_valid = wb_valid_q;
  assign ALU_res  = alu_q;
  assign Mem_res  = mem_q;
  assign PC       = pc_q;
  assign MemtoReg = mtr_q;
  assign RegWrite = regwrite_q;
  assign rd       = rd_q;
  assign bus_err  = bus_err_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign = mis_q;
`endif

endmodule
